// File: rtl/smg_pkg.sv
`default_nettype none
//==============================================================================
// Module      : smg_pkg
// Description : Shared constants for the multiplexed 7-segment driver.
//               Provides the hex-to-segment table in active-high form,
//               {g,f,e,d,c,b,a} bit order, and the pin idle levels for each
//               polarity.
// Revision    : 1.0 - initial release
//==============================================================================
package smg_pkg;

   // Entry n is the active-high segment pattern for hex digit n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

   // Segment bus levels that leave every segment dark.
   localparam logic [6:0] SEG_OFF_ACT_HIGH = 7'h00;
   localparam logic [6:0] SEG_OFF_ACT_LOW  = 7'h7F;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage
`default_nettype wire

// File: rtl/smg_hex_decoder.sv
`default_nettype none
//==============================================================================
// Module      : smg_hex_decoder
// Description : Combinational hex nibble to 7-segment decoder with selectable
//               output polarity.
// Ports       : nibble_i [3:0] - hex value to display
//               seg_o    [6:0] - segments {g,f,e,d,c,b,a} at pin polarity
// Revision    : 1.0 - initial release
//==============================================================================
module smg_hex_decoder
   import smg_pkg::*;
#(
   parameter int SEG_ACT_LOW = 1
)(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = hex_to_seg(nibble_i);
      if (SEG_ACT_LOW != 0) begin
         seg_o = ~seg_o;
      end
   end

endmodule
`default_nettype wire

// File: rtl/smg_scan_driver.sv
`default_nettype none
//==============================================================================
// Module      : smg_scan_driver
// Description : Parametrised multiplexed 7-segment scan driver with frame-
//               synchronous double buffering, per-digit decimal points,
//               leading-zero blanking, PWM brightness and dead time.
// Ports       : CLK, RSTn          - clock, asynchronous active-low reset
//               Number_Sig         - hex nibbles, nibble i -> digit i
//               DP_Sig             - decimal point per digit
//               LZ_En              - leading-zero blanking enable
//               Brightness         - PWM duty code
//               SMG_Data, SMG_DP   - segment and decimal-point pins
//               Scan_Sig           - one-hot digit select pins
//               Frame_Done         - one-cycle pulse at each frame wrap
// Revision    : 1.0 - initial release
//==============================================================================
module smg_scan_driver
   import smg_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CLKS    = 16,
   parameter int BRIGHT_W     = 4,
   parameter int SEG_ACT_LOW  = 1,
   parameter int SCAN_ACT_LOW = 1
)(
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic [4*DIGITS-1:0]   Number_Sig,
   input  logic [DIGITS-1:0]     DP_Sig,
   input  logic                  LZ_En,
   input  logic [BRIGHT_W-1:0]   Brightness,
   output logic [6:0]            SMG_Data,
   output logic                  SMG_DP,
   output logic [DIGITS-1:0]     Scan_Sig,
   output logic                  Frame_Done
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Idle pin levels; XOR-ing an active-high value with these applies polarity.
   localparam logic [6:0]        SEG_OFF  = (SEG_ACT_LOW != 0) ? SEG_OFF_ACT_LOW : SEG_OFF_ACT_HIGH;
   localparam logic              DP_OFF   = (SEG_ACT_LOW != 0);
   localparam logic [DIGITS-1:0] SCAN_OFF = (SCAN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BRIGHT_W-1:0]   pwm_q;

   // Shadow copies of the inputs, refreshed only at frame wrap.
   logic [4*DIGITS-1:0]   num_q;
   logic [DIGITS-1:0]     dp_q;
   logic                  lz_q;
   logic [BRIGHT_W-1:0]   br_q;

   logic [DIGITS-1:0]     scan_q, scan_d;
   logic [6:0]            seg_q, seg_d;
   logic                  smgdp_q, smgdp_d;
   logic                  fd_q;

   logic                  tick;
   logic                  frame_wrap;
   logic [DIGITS-1:0]     blank;
   logic [3:0]            nibble;
   logic [6:0]            seg_dec;
   logic                  cur_blank;
   logic                  active;

   assign tick       = (presc_q == PW'(SCAN_DIV - 1));
   assign frame_wrap = tick && (idx_q == IW'(DIGITS - 1));

   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (tick) begin
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // A digit is blanked when it and every more-significant nibble are zero.
   // Walking from the top keeps a running "all zero so far" flag.
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      blank    = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero & (num_q[4*i +: 4] == 4'h0);
         blank[i] = lz_q & all_zero;
      end
   end

   assign nibble = num_q[{idx_q, 2'b00} +: 4];

   smg_hex_decoder #(
      .SEG_ACT_LOW (SEG_ACT_LOW)
   ) u_hex_decoder (
      .nibble_i (nibble),
      .seg_o    (seg_dec)
   );

   always_comb begin
      cur_blank = blank[idx_q];
      active    = (presc_q >= PW'(DEAD_CLKS)) && (pwm_q <= br_q) && !cur_blank;
      scan_d    = (active ? (DIGITS'(1) << idx_q) : '0) ^ SCAN_OFF;
      seg_d     = cur_blank ? SEG_OFF : seg_dec;
      smgdp_d   = (dp_q[idx_q] & ~cur_blank) ^ DP_OFF;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         presc_q <= '0;
         idx_q   <= '0;
         pwm_q   <= '0;
         num_q   <= '0;
         dp_q    <= '0;
         lz_q    <= 1'b0;
         br_q    <= '0;
         scan_q  <= SCAN_OFF;
         seg_q   <= SEG_OFF;
         smgdp_q <= DP_OFF;
         fd_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         pwm_q   <= pwm_q + 1'b1;
         if (frame_wrap) begin
            num_q <= Number_Sig;
            dp_q  <= DP_Sig;
            lz_q  <= LZ_En;
            br_q  <= Brightness;
         end
         scan_q  <= scan_d;
         seg_q   <= seg_d;
         smgdp_q <= smgdp_d;
         fd_q    <= frame_wrap;
      end
   end

   assign Scan_Sig   = scan_q;
   assign SMG_Data   = seg_q;
   assign SMG_DP     = smgdp_q;
   assign Frame_Done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_smg_scan_driver.sv
`default_nettype none
//==============================================================================
// Module      : tb_smg_scan_driver
// Description : Self-checking bench for smg_scan_driver (4 digits, 8 clocks
//               per slot, 1 dead clock, 2-bit brightness, active-low pins).
//               Expected pins are derived from the elapsed clock count since
//               reset release and a frame-latched copy of the inputs.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_smg_scan_driver;

   localparam int DG   = 4;
   localparam int SD   = 8;
   localparam int DEAD = 1;
   localparam int BW   = 2;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic [15:0]   Number_Sig;
   logic [3:0]    DP_Sig;
   logic          LZ_En;
   logic [1:0]    Brightness;
   logic [6:0]    SMG_Data;
   logic          SMG_DP;
   logic [3:0]    Scan_Sig;
   logic          Frame_Done;

   smg_scan_driver #(
      .DIGITS       (DG),
      .SCAN_DIV     (SD),
      .DEAD_CLKS    (DEAD),
      .BRIGHT_W     (BW),
      .SEG_ACT_LOW  (1),
      .SCAN_ACT_LOW (1)
   ) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .Number_Sig (Number_Sig),
      .DP_Sig     (DP_Sig),
      .LZ_En      (LZ_En),
      .Brightness (Brightness),
      .SMG_Data   (SMG_Data),
      .SMG_DP     (SMG_DP),
      .Scan_Sig   (Scan_Sig),
      .Frame_Done (Frame_Done)
   );

   always #5 CLK = ~CLK;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n;          // rising edges since reset release
   logic [6:0]  seg_tab [16];
   logic [15:0] sh_num;
   logic [3:0]  sh_dp;
   logic        sh_lz;
   logic [1:0]  sh_br;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_scan"}, 8'(Scan_Sig), 8'h0F);
      chk({tag, "_seg"},  8'(SMG_Data), 8'h7F);
      chk({tag, "_dp"},   8'(SMG_DP),   8'h01);
      chk({tag, "_fd"},   8'(Frame_Done), 8'h00);
   endtask

   // One clock: predict the pins from the pre-edge position in the frame,
   // advance, then compare.
   task automatic step();
      int         p, k, w;
      logic       blk, act;
      logic [3:0] nib, e_scan;
      logic [6:0] e_seg;
      logic       e_dp, e_fd;
      p      = n % SD;
      k      = (n / SD) % DG;
      w      = n % (1 << BW);
      nib    = sh_num[4*k +: 4];
      blk    = sh_lz && (k > 0) && ((sh_num >> (4*k)) == 16'h0);
      act    = (p >= DEAD) && (w <= int'(sh_br)) && !blk;
      e_scan = act ? ~(4'b0001 << k) : 4'b1111;
      e_seg  = blk ? 7'h7F : ~seg_tab[nib];
      e_dp   = !(sh_dp[k] && !blk);
      e_fd   = (p == SD - 1) && (k == DG - 1);
      if (e_fd) begin
         sh_num = Number_Sig;
         sh_dp  = DP_Sig;
         sh_lz  = LZ_En;
         sh_br  = Brightness;
      end
      @(posedge CLK);
      #1;
      n++;
      chk("scan",   8'(Scan_Sig),   8'(e_scan));
      chk("seg",    8'(SMG_Data),   8'(e_seg));
      chk("dp",     8'(SMG_DP),     8'(e_dp));
      chk("fdone",  8'(Frame_Done), 8'(e_fd));
      chk("onehot", 8'($countones(~Scan_Sig) <= 1), 8'h01);
   endtask

   task automatic run(input int cycles);
      for (int c = 0; c < cycles; c++) step();
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RSTn   = 1'b1;
      n      = 0;
      sh_num = '0;
      sh_dp  = '0;
      sh_lz  = 1'b0;
      sh_br  = '0;
   endtask

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      n          = 0;
      RSTn       = 1'b0;
      Number_Sig = '0;
      DP_Sig     = '0;
      LZ_En      = 1'b0;
      Brightness = '0;

      // Reset held for five clocks.
      repeat (5) @(posedge CLK);
      #1;
      chk_reset_vals("reset");

      // Hex digits, full brightness; the first frame still shows blank shadows.
      Number_Sig = 16'h12AF;
      Brightness = 2'd3;
      release_reset();
      run(3 * 32);

      // Leading-zero blanking.
      Number_Sig = 16'h0030;
      LZ_En      = 1'b1;
      run(2 * 32);
      Number_Sig = 16'h0000;
      run(2 * 32);

      // Brightness duty codes.
      Number_Sig = 16'h5678;
      LZ_En      = 1'b0;
      Brightness = 2'd0;
      run(2 * 32);
      Brightness = 2'd2;
      run(2 * 32);

      // Mid-frame change must wait for the frame wrap.
      Number_Sig = 16'h1111;
      Brightness = 2'd3;
      run(2 * 32 + 13);
      Number_Sig = 16'h2222;
      run(2 * 32);

      // Decimal point on digit 2.
      DP_Sig = 4'b0100;
      run(2 * 32 + 19);

      // Asynchronous reset mid-slot, checked with no clock edge in between.
      RSTn = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      @(posedge CLK);
      #1;
      chk_reset_vals("rst_hold");
      release_reset();
      run(2 * 32);

      // Randomised inputs changing at arbitrary cycles.
      for (int c = 0; c < 10 * 32; c++) begin
         if ($urandom_range(0, 7) == 0)  Number_Sig = 16'($urandom) >> (4 * $urandom_range(0, 4));
         if ($urandom_range(0, 15) == 0) DP_Sig     = 4'($urandom);
         if ($urandom_range(0, 15) == 0) LZ_En      = 1'($urandom);
         if ($urandom_range(0, 15) == 0) Brightness = 2'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
